// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: payload + valid, flush, bubble insertion with a
// saturating bubble counter, sticky overrun flag and an optional one-entry
// skid buffer enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter int unsigned      CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall_current_stage,
  input  logic                 stall_next_stage,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out,
  output logic                 skid_full,
  output logic                 overrun_err,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  logic [WIDTH-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 skid_valid_q;
  logic [WIDTH-1:0]     skid_data_q;

`ifdef PIPE_STAGE_SKID_EN
  logic                 skid_valid_d;
  logic [WIDTH-1:0]     skid_data_d;

  // Skid entry register.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= BUBBLE_VALUE;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // No skid storage: drain branches below fold away.
  assign skid_valid_q = 1'b0;
  assign skid_data_q  = BUBBLE_VALUE;
`endif

  // Next-state selection in priority order: flush, bubble/drain, hold, advance, capture.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
`endif
    if (flush) begin
      out_d       = BUBBLE_VALUE;
      out_valid_d = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (stall_current_stage && !stall_next_stage) begin
      if (skid_valid_q) begin
        // Drain the skid entry; not counted as a bubble.
        out_d       = skid_data_q;
        out_valid_d = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_d = 1'b0;
`endif
      end else begin
        out_d       = BUBBLE_VALUE;
        out_valid_d = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (stall_current_stage && stall_next_stage) begin
      // Hold everything.
    end else if (!stall_next_stage) begin
      if (skid_valid_q) begin
        // Older skid entry goes out first; incoming payload takes its place.
        out_d       = skid_data_q;
        out_valid_d = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_d = in_valid;
        if (in_valid) skid_data_d = in;
`endif
      end else begin
        out_d       = in;
        out_valid_d = in_valid;
      end
    end else begin
      // Downstream stalled while upstream still pushing.
`ifdef PIPE_STAGE_SKID_EN
      if (in_valid) begin
        if (!skid_valid_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in;
        end else begin
          overrun_d = 1'b1;
        end
      end
`else
      overrun_d = 1'b1;
`endif
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= BUBBLE_VALUE;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign skid_full   = skid_valid_q;
  assign overrun_err = overrun_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: constant vector table, directed
// skid/overrun/flush sequences, then random stimulus against a queue model.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam logic [W-1:0] BV = '0;

  logic          clk = 1'b0;
  logic          rst, flush, sc, sn, iv;
  logic [W-1:0]  din;
  logic          dut_valid, dut_skid, dut_err;
  logic [W-1:0]  dut_out;
  logic [CW-1:0] dut_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: skid held as a queue of pending payloads.
  logic [W-1:0] m_out;
  logic         m_valid;
  logic [W-1:0] skid_q[$];
  logic         m_err;
  int           m_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(W),
    .BUBBLE_VALUE(BV),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .stall_current_stage(sc),
    .stall_next_stage(sn),
    .in_valid(iv),
    .in(din),
    .out_valid(dut_valid),
    .out(dut_out),
    .skid_full(dut_skid),
    .overrun_err(dut_err),
    .bubble_cnt(dut_cnt)
  );

  typedef struct packed {
    logic         r, f, sc, sn, iv;
    logic [W-1:0] din;
    logic [W-1:0] eout;
    logic         ev, es, ee;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eo, input logic ev,
                         input logic es, input logic ee, input int ec);
    chk({tag, ".out"}, 64'(dut_out), 64'(eo));
    chk({tag, ".out_valid"}, 64'(dut_valid), 64'(ev));
    chk({tag, ".skid_full"}, 64'(dut_skid), 64'(es));
    chk({tag, ".overrun_err"}, 64'(dut_err), 64'(ee));
    chk({tag, ".bubble_cnt"}, 64'(dut_cnt), 64'(ec));
  endtask

  // Apply one cycle of inputs, advance the model on the edge, settle outputs.
  task automatic step(input logic r, input logic f, input logic s_c, input logic s_n,
                      input logic v, input logic [W-1:0] d);
    rst = r; flush = f; sc = s_c; sn = s_n; iv = v; din = d;
    @(posedge clk);
    if (r) begin
      m_out = BV; m_valid = 1'b0; skid_q.delete(); m_err = 1'b0; m_cnt = 0;
    end else if (f) begin
      m_out = BV; m_valid = 1'b0; skid_q.delete();
    end else if (s_c && !s_n) begin
      if (skid_q.size() > 0) begin
        m_out = skid_q.pop_front(); m_valid = 1'b1;
      end else begin
        m_out = BV; m_valid = 1'b0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else if (s_c && s_n) begin
      // hold
    end else if (!s_n) begin
      if (skid_q.size() > 0) begin
        m_out = skid_q.pop_front(); m_valid = 1'b1;
        if (v) skid_q.push_back(d);
      end else begin
        m_out = d; m_valid = v;
      end
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      if (v) begin
        if (skid_q.size() == 0) skid_q.push_back(d);
        else m_err = 1'b1;
      end
`else
      m_err = 1'b1;
`endif
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sc = 1'b0; sn = 1'b0; iv = 1'b0; din = '0;
    m_out = BV; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;

    // {r, f, sc, sn, iv, din, eout, ev, es, ee, ec}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3333_3333, 32'h0, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4444_4444, 32'h0, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5555_5555, 32'h0, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7777_7777, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_0000, 32'h5555_0000, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h9999_9999, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].sc, tbl[i].sn, tbl[i].iv, tbl[i].din);
      chk_all($sformatf("vec%0d", i), tbl[i].eout, tbl[i].ev, tbl[i].es, tbl[i].ee,
              int'(tbl[i].ec));
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid capture, drain, advance.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA);
    chk_all("skid.a", 32'hA, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB);
    chk_all("skid.capture", 32'hA, 1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_all("skid.drain", 32'hB, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC);
    chk_all("skid.adv", 32'hC, 1'b1, 1'b0, 1'b0, 0);
    // Overrun: second push while skid full is dropped.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD);
    chk_all("ovr.capture", 32'hC, 1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hE);
    chk_all("ovr.drop", 32'hC, 1'b1, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_all("ovr.keep", 32'hD, 1'b1, 1'b0, 1'b1, 0);
    // Flush with skid full, then no residue.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF);
    chk_all("flush.pre", 32'hD, 1'b1, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6);
    chk_all("flush.adv", 32'h0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    chk_all("flush.post", 32'h8, 1'b0, 1'b0, 1'b1, 0);
    // Reset with skid full.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h9);
    chk_all("rstskid.pre", 32'h8, 1'b0, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3);
    chk_all("rstskid.rst", 32'h0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4);
    chk_all("rstskid.post", 32'h4, 1'b1, 1'b0, 1'b0, 0);
`else
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA);
    chk_all("noskid.a", 32'hA, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB);
    chk_all("noskid.ovr", 32'hA, 1'b1, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC);
    chk_all("noskid.ovr_iv0", 32'hA, 1'b1, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB);
    chk_all("noskid.sticky", 32'hB, 1'b1, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC);
    chk_all("noskid.flush_bubble", 32'h0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_all("noskid.rst", 32'h0, 1'b0, 1'b0, 1'b0, 0);
`endif

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom);
      chk_all($sformatf("rnd%0d", n), m_out, m_valid, (skid_q.size() > 0), m_err, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid tracking, flush, and bubble insertion. It generalises the per-field `PipelineDeliver` flops into one register: a single WIDTH-bit payload plus a valid bit, a saturating bubble counter, and an optional one-entry skid buffer. Instances sit between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Stage fields are concatenated into `in`/`out` by the wrapper.

## Interface
- `WIDTH`, default 32: payload width in bits (≥1).
- `BUBBLE_VALUE`, default {WIDTH{1'b0}}: payload loaded on bubble, flush, or reset.
- `CNT_WIDTH`, default 16: bubble counter width (≥1).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard stage contents (branch or exception redirect).
- `stall_current_stage` in 1: upstream stage is stalled.
- `stall_next_stage` in 1: downstream stage is stalled.
- `in_valid` in 1: upstream payload is valid.
- `in` in WIDTH: upstream payload.
- `out_valid` out 1: registered valid.
- `out` out WIDTH: registered payload.
- `skid_full` out 1: skid entry occupied. Tied 0 when skid is compiled out.
- `overrun_err` out 1: sticky protocol-violation flag.
- `bubble_cnt` out CNT_WIDTH: saturating count of inserted bubbles.

## Operation
Per-edge priority, highest first:
1. `rst`:
   - out=BUBBLE_VALUE, out_valid=0.
   - Skid cleared; skid_full=0.
   - overrun_err=0, bubble_cnt=0.
2. `flush`:
   - out=BUBBLE_VALUE, out_valid=0.
   - Skid cleared.
   - bubble_cnt and overrun_err unchanged.
   - Flush overrides all stall combinations.
3. `stall_current_stage`=1, `stall_next_stage`=0 (bubble):
   - With skid full: out←skid, out_valid←1, skid cleared. This is a drain, not a bubble.
   - Otherwise: out=BUBBLE_VALUE, out_valid=0, bubble_cnt+1, saturating at all-ones.
4. Both stalls 1: hold out, out_valid, and skid.
5. `stall_current_stage`=0, `stall_next_stage`=0 (advance):
   - Skid empty: out←in, out_valid←in_valid.
   - Skid full: out←skid, skid←in if in_valid, else skid cleared. This preserves order.
6. `stall_current_stage`=0, `stall_next_stage`=1 (downstream stalled, upstream not):
   - Skid compiled in:
     - Skid empty and in_valid=1: skid←in; skid_full=1 from next cycle; out held.
     - in_valid=0: no capture.
     - Skid already full and in_valid=1: incoming payload dropped, overrun_err←1.
   - Skid compiled out: this combination is a protocol violation.
     - overrun_err←1.
     - out held; payload dropped.
- `skid_full` means upstream must assert `stall_current_stage` on the next cycle. The stall controller consumes it combinationally from the register output.
- `overrun_err` clears only on `rst`.

## Timing
- Latency: 1 cycle, `in` to `out`, on an advance edge.
- Skid path: 2 cycles minimum (capture edge, then drain edge).
- All outputs are registered; there is no combinational path from inputs to outputs.
- `bubble_cnt` updates on the same edge as the bubble it counts.
- Flush asserted in the same cycle as any stall pattern: flush wins, and the bubble is not counted.
- Reset mid-stall or with the skid full: everything cleared on that edge. Operation resumes on the next edge with no residue.
- Bubble counter at all-ones: stays at all-ones. No wrap.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - One-entry skid register of WIDTH+1 bits.
  - Rules 3, 5 and 6 skid behaviour active.
  - `skid_full` is driven by the register.
- Not defined:
  - No skid storage is synthesised; `skid_full` is constant 0.
  - Rule 6 only sets `overrun_err` and holds `out`.
  - Drain branches are unreachable.
  - Behaviour otherwise matches the classic stall/bubble register.

## Test plan
- **Reset then advance:** rst 1 cycle, then in=32'hDEAD_BEEF, in_valid=1, no stalls → out=DEADBEEF, out_valid=1 one edge later. All outputs are 0 during reset.
- **Bubble and saturation:** CNT_WIDTH=2, stall_current_stage=1, stall_next_stage=0 for 5 cycles → out=BUBBLE_VALUE, out_valid=0, bubble_cnt=1,2,3,3,3.
- **Hold:** both stalls 1 for 4 cycles with out=32'h1234 → out stays 32'h1234 and out_valid stays 1. bubble_cnt is unchanged.
- **Skid (macro defined):**
  - out=A with stall_next_stage=1, then in=B, in_valid=1, stall_current_stage=0 → skid_full=1, out=A.
  - Then stall_current_stage=1, stall_next_stage=0 → out=B, skid_full=0.
  - Then advance with in=C → out=C.
- **Overrun:**
  - Macro defined: skid full and a second in_valid=1 with stall_next_stage=1 → overrun_err=1 sticky, skid keeps B.
  - Macro undefined: any stall_current_stage=0, stall_next_stage=1 → overrun_err=1.
- **Flush priority:** flush=1 together with advance, with the skid full → out=BUBBLE_VALUE, out_valid=0, skid_full=0, bubble_cnt unchanged. overrun_err stays at its prior value.
